cla_final: RTL and testbench

- Registered 5-bit carry-lookahead adder computing {Cout_out, S_out} = A_in + B_in + Cin_in.
- Inputs are captured in an input register stage and added by flattened, two-level carry-lookahead logic; no ripple carry is permitted.
- Sum and carry-out are captured in an output register stage.
- Used as a pipelined arithmetic leaf block in a single clock domain.

---
 rtl/cla_pkg.sv | 8 +
 rtl/cla_core_5b.sv | 45 ++++
 rtl/cla_final.sv | 53 +++++
 tb/tb_cla_final.sv | 138 +++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared width constant and operand type for the 5-bit carry-lookahead adder.
package cla_pkg;

  localparam int CLA_WIDTH = 5;

  typedef logic [CLA_WIDTH-1:0] operand_t;

endpackage

// File: rtl/cla_core_5b.sv
// Combinational 5-bit carry-lookahead core: every carry is a two-level
// sum-of-products of G, P and the carry-in, with no carry feeding another.
module cla_core_5b
  import cla_pkg::*;
(
  input  operand_t a,
  input  operand_t b,
  input  logic     cin,
  output operand_t s,
  output logic     cout
);

  operand_t             g;
  operand_t             p;
  logic [CLA_WIDTH:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = cin;
  assign c[1] = g[0]
              | (p[0] & cin);
  assign c[2] = g[1]
              | (p[1] & g[0])
              | (p[1] & p[0] & cin);
  assign c[3] = g[2]
              | (p[2] & g[1])
              | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3]
              | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);
  assign c[5] = g[4]
              | (p[4] & g[3])
              | (p[4] & p[3] & g[2])
              | (p[4] & p[3] & p[2] & g[1])
              | (p[4] & p[3] & p[2] & p[1] & g[0])
              | (p[4] & p[3] & p[2] & p[1] & p[0] & cin);

  assign s    = p ^ c[CLA_WIDTH-1:0];
  assign cout = c[CLA_WIDTH];

endmodule

// File: rtl/cla_final.sv
// Two-stage registered 5-bit adder: operands registered, summed by the
// lookahead core, and the 6-bit result registered again (2-cycle latency).
module cla_final
  import cla_pkg::*;
(
  input  logic     CLK,
  input  logic     RST_N,
  input  operand_t A_in,
  input  operand_t B_in,
  input  logic     Cin_in,
  output operand_t S_out,
  output logic     Cout_out
);

  operand_t a_p0;
  operand_t b_p0;
  logic     cin_p0;
  operand_t sum_p0;
  logic     cout_p0;

  // Stage 0: operand capture
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      a_p0   <= '0;
      b_p0   <= '0;
      cin_p0 <= 1'b0;
    end else begin
      a_p0   <= A_in;
      b_p0   <= B_in;
      cin_p0 <= Cin_in;
    end
  end

  cla_core_5b u_core (
    .a    (a_p0),
    .b    (b_p0),
    .cin  (cin_p0),
    .s    (sum_p0),
    .cout (cout_p0)
  );

  // Stage 1: result capture
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      S_out    <= '0;
      Cout_out <= 1'b0;
    end else begin
      S_out    <= sum_p0;
      Cout_out <= cout_p0;
    end
  end

endmodule

// File: tb/tb_cla_final.sv
// Bench for cla_final: directed corner vectors, a pipelined stream, an
// exhaustive sweep with a mid-stream async reset, and random vectors.
module tb_cla_final;

  logic       CLK;
  logic       RST_N;
  logic [4:0] A_in;
  logic [4:0] B_in;
  logic       Cin_in;
  logic [4:0] S_out;
  logic       Cout_out;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected results in the order the DUT will present them; the
  // reference is plain integer addition.
  logic [5:0] exp_q[$];

  cla_final dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .A_in     (A_in),
    .B_in     (B_in),
    .Cin_in   (Cin_in),
    .S_out    (S_out),
    .Cout_out (Cout_out)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (S=%0d C=%0d), expected %0d", tag, obs, obs[4:0], obs[5], exp);
    end
  endtask

  function automatic logic [5:0] ref_sum(input int a, input int b, input int c);
    int r;
    r = a + b + c;
    return r[5:0];
  endfunction

  // Called at a negedge: drive a vector, let one rising edge pass, then
  // compare against the result of the vector two edges back.
  task automatic cycle(input string tag, input int a, input int b, input int c);
    A_in   = a[4:0];
    B_in   = b[4:0];
    Cin_in = c[0];
    @(posedge CLK);
    exp_q.push_back(ref_sum(a, b, c));
    @(negedge CLK);
    check_eq(tag, {Cout_out, S_out}, exp_q[exp_q.size()-2]);
  endtask

  task automatic expect_from_reset();
    exp_q.delete();
    exp_q.push_back(6'd0);
  endtask

  initial begin
    int rst_point;
    int a, b, c;

    A_in   = 5'd31;
    B_in   = 5'd31;
    Cin_in = 1'b1;
    RST_N  = 1'b0;

    // Reset held for 3 cycles with maximal operands on the inputs
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check_eq("reset_hold", {Cout_out, S_out}, 6'd0);
    end
    RST_N = 1'b1;
    expect_from_reset();
    cycle("post_reset_first", 31, 31, 1);
    cycle("post_reset_63", 31, 31, 1);

    // Corner vectors, each held long enough to reach the output
    cycle("chain_31_0_1", 31, 0, 1);
    cycle("chain_31_0_1", 31, 0, 1);
    cycle("chain_31_1_0", 31, 1, 0);
    cycle("chain_31_1_0", 31, 1, 0);
    cycle("prop_21_10_0", 21, 10, 0);
    cycle("prop_21_10_0", 21, 10, 0);
    cycle("prop_21_10_1", 21, 10, 1);
    cycle("prop_21_10_1", 21, 10, 1);
    cycle("gen_16_16_0", 16, 16, 0);
    cycle("gen_16_16_0", 16, 16, 0);
    cycle("gen_15_1_0", 15, 1, 0);
    cycle("gen_15_1_0", 15, 1, 0);

    // Back-to-back stream, a new vector every cycle
    cycle("pipe", 3, 4, 0);
    cycle("pipe", 7, 9, 1);
    cycle("pipe", 0, 0, 0);
    for (int i = 0; i < 17; i++)
      cycle("pipe", $urandom_range(31), $urandom_range(31), $urandom_range(1));

    // Exhaustive sweep with an asynchronous reset dropped in off-edge
    rst_point = $urandom_range(1500, 300);
    for (int i = 0; i < 2048; i++) begin
      a = (i >> 6) & 31;
      b = (i >> 1) & 31;
      c = i & 1;
      cycle("sweep", a, b, c);
      if (i == rst_point) begin
        #2;
        RST_N = 1'b0;
        #1;
        check_eq("async_reset_immediate", {Cout_out, S_out}, 6'd0);
        @(posedge CLK);
        @(negedge CLK);
        check_eq("async_reset_held", {Cout_out, S_out}, 6'd0);
        RST_N = 1'b1;
        expect_from_reset();
      end
    end

    // Random vectors
    for (int i = 0; i < 200; i++)
      cycle("random", $urandom_range(31), $urandom_range(31), $urandom_range(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
